// File: rtl/data_mem_port.sv
// Single-ported data memory behind a valid/yumi handshake. It holds one request
// at a time, waits a fixed latency, then holds the response until the core yumis it.
`timescale 1ns/1ps

package data_mem_port_pkg;
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;
endpackage

module data_mem_port
    import data_mem_port_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] data_mem_addr,
    output mem_out_s    from_mem_o,
    output logic        busy_o
);

    generate
        if (latency_p < 1 || latency_p > 15) begin : g_bad_latency
            $error("data_mem_port: latency_p must be in 1..15");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(latency_p - 1);

    logic [1:0]              state;
    logic [3:0]              cnt;
    logic [addr_width_p-1:0] word_idx;
    logic [1:0]              lane;
    logic [31:0]             wdata;
    logic                    wen_q;
    logic                    bnw_q;
    logic [31:0]             read_data;
    logic [31:0]             mem [2**addr_width_p];
    logic                    do_access;

    // High address bits are deliberately dropped so addresses wrap.
    wire unused_addr = &{1'b0, data_mem_addr[31:addr_width_p+2]};

    assign do_access = (state == ST_BUSY) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            word_idx  <= '0;
            lane      <= 2'd0;
            wdata     <= 32'd0;
            wen_q     <= 1'b0;
            bnw_q     <= 1'b0;
            read_data <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: if (to_mem_i.valid) begin
                    state    <= ST_BUSY;
                    cnt      <= CNT_INIT;
                    word_idx <= data_mem_addr[addr_width_p+1:2];
                    lane     <= data_mem_addr[1:0];
                    wdata    <= to_mem_i.write_data;
                    wen_q    <= to_mem_i.wen;
                    bnw_q    <= to_mem_i.byte_not_word;
                end
                ST_BUSY: if (cnt == 4'd0) begin
                    state <= ST_RESP;
                    if (wen_q)      read_data <= 32'd0;
                    else if (bnw_q) read_data <= {24'd0, mem[word_idx][8*lane +: 8]};
                    else            read_data <= mem[word_idx];
                end else begin
                    cnt <= cnt - 4'd1;
                end
                ST_RESP: if (to_mem_i.yumi) begin
                    state     <= ST_IDLE;
                    read_data <= 32'd0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Array is not reset; writes are gated by the reset-controlled state.
    always_ff @(posedge clk) begin
        if (do_access && wen_q) begin
            if (bnw_q) mem[word_idx][8*lane +: 8] <= wdata[7:0];
            else       mem[word_idx]              <= wdata;
        end
    end

    always_comb begin
        from_mem_o           = '0;
        from_mem_o.read_data = read_data;
        from_mem_o.valid     = (state == ST_RESP);
        from_mem_o.yumi      = (state == ST_IDLE) && to_mem_i.valid;
    end

    assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: a latency-2 instance for the main traffic and a
// latency-4 instance for the reset-during-BUSY case.
`timescale 1ns/1ps

module tb_data_mem_port;
    import data_mem_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    mem_in_s     req  [2];
    logic [31:0] addr [2];
    mem_out_s    rsp  [2];
    logic        bsy  [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    data_mem_port #(.addr_width_p(10), .latency_p(2)) dut2 (
        .clk(clk), .reset(rst_n), .to_mem_i(req[0]), .data_mem_addr(addr[0]),
        .from_mem_o(rsp[0]), .busy_o(bsy[0]));

    data_mem_port #(.addr_width_p(10), .latency_p(4)) dut4 (
        .clk(clk), .reset(rst_n), .to_mem_i(req[1]), .data_mem_addr(addr[1]),
        .from_mem_o(rsp[1]), .busy_o(bsy[1]));

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for the response, check latency and data, then yumi it.
    task automatic finish_txn(input int s, input int lat, input logic [31:0] exp, input string tag);
        int n = 0;
        while (!rsp[s].valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 34'(n), 34'(lat));
        check({tag, "_data"}, 34'(rsp[s].read_data), 34'(exp));
        @(negedge clk);
        req[s].yumi = 1'b1;
        @(posedge clk); #1;
        req[s].yumi = 1'b0;
        check({tag, "_idle_valid"}, 34'(rsp[s].valid), 34'd0);
        check({tag, "_idle_busy"}, 34'(bsy[s]), 34'd0);
        check({tag, "_idle_rdata"}, 34'(rsp[s].read_data), 34'd0);
    endtask

    task automatic drive(input int s, input logic w, input logic b,
                         input logic [31:0] a, input logic [31:0] wd);
        req[s]  = '{write_data: wd, valid: 1'b1, wen: w, byte_not_word: b, yumi: 1'b0};
        addr[s] = a;
    endtask

    task automatic txn(input int s, input logic w, input logic b, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp, input string tag);
        @(negedge clk);
        drive(s, w, b, a, wd);
        #1;
        check({tag, "_accept"}, 34'(rsp[s].yumi), 34'd1);
        @(posedge clk); #1;
        req[s].valid = 1'b0;
        finish_txn(s, (s == 0) ? 2 : 4, exp, tag);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i]  = '0;
            addr[i] = 32'd0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out2", 34'(rsp[0]), 34'd0);
        check("reset_busy2", 34'(bsy[0]), 34'd0);
        check("reset_out4", 34'(rsp[1]), 34'd0);
        @(negedge clk);
        rst_n = 1'b1;

        txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, "st_word");
        txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "ld_word");
        txn(0, 1'b1, 1'b1, 32'h12, 32'hFFFFFFAA, 32'h0, "st_byte");
        txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAABEEF, "ld_merged");
        txn(0, 1'b0, 1'b1, 32'h13, 32'h0, 32'h000000DE, "ld_byte");

        // Held response: no yumi for 5 cycles, one stray valid in the middle.
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        req[0].valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold_first_valid", 34'(rsp[0].valid), 34'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req[0].valid = (i == 2);
            #1;
            check("hold_valid", 34'(rsp[0].valid), 34'd1);
            check("hold_data", 34'(rsp[0].read_data), 34'(32'hDEAABEEF));
            check("hold_no_accept", 34'(rsp[0].yumi), 34'd0);
            @(posedge clk); #1;
            req[0].valid = 1'b0;
        end
        // Yumi together with a new valid: accepted only in the following cycle.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h13, 32'h0);
        req[0].yumi = 1'b1;
        #1;
        check("same_cycle_no_accept", 34'(rsp[0].yumi), 34'd0);
        @(posedge clk); #1;
        req[0].yumi = 1'b0;
        check("post_yumi_idle", 34'(bsy[0]), 34'd0);
        check("post_yumi_valid", 34'(rsp[0].valid), 34'd0);
        check("next_cycle_accept", 34'(rsp[0].yumi), 34'd1);
        @(posedge clk); #1;
        req[0].valid = 1'b0;
        check("next_req_busy", 34'(bsy[0]), 34'd1);
        finish_txn(0, 2, 32'h000000DE, "ld_after_hold");

        txn(0, 1'b1, 1'b0, 32'h1004, 32'h12345678, 32'h0, "st_wrap");
        txn(0, 1'b0, 1'b0, 32'h0004, 32'h0, 32'h12345678, "ld_wrap");
        txn(0, 1'b0, 1'b0, 32'h0006, 32'h0, 32'h12345678, "ld_unaligned");

        // Reset during BUSY on the latency-4 instance must cancel the store.
        txn(1, 1'b1, 1'b0, 32'h20, 32'h11111111, 32'h0, "l4_st_init");
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h5555AAAA);
        @(posedge clk); #1;
        req[1].valid = 1'b0;
        check("l4_busy1", 34'(bsy[1]), 34'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("l4_rst_out", 34'(rsp[1]), 34'd0);
        check("l4_rst_busy", 34'(bsy[1]), 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h11111111, "l4_ld_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
